// File: rtl/data_unpacker.sv
// data_unpacker
// Re-emits the elements of a packed N-wide trace vector as beats of N, M or
// 1 elements, chosen per chain by an 8-bit firmware byte. One packed vector
// is buffered and drained over several cycles under ready/valid backpressure.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   tracing           : enables acceptance of new packed vectors
//   valid_in/ready_in : packed-vector handshake (ready_in is combinational)
//   vector_in         : N elements of DATA_WIDTH bits, element i at [i*DW +: DW]
//   count_in          : number of valid elements (clamped to N)
//   chainId_in        : chain of the packed vector, selects the firmware entry
//   configId/configData : firmware shift-in bus, active while tracing==0
//   vector_out        : current beat, oldest element at index 0, zero padded
//   valid_out/ready_out : beat handshake
//   last_out          : final beat of the current packed vector
//   chainId_out       : chain of the current beat
//   drop_count        : saturating count of dropped / empty vectors
//                       (only when DATA_UNPACKER_DROP_CNT_EN is defined)
//
// Optional feature macro: DATA_UNPACKER_DROP_CNT_EN
module data_unpacker #(
  parameter int N = 8,
  parameter int M = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE = '0,
  localparam int CW = $clog2(N) + 1,
  localparam int CIW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tracing,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [N*DATA_WIDTH-1:0] vector_in,
  input  logic [CW-1:0]           count_in,
  input  logic [CIW-1:0]          chainId_in,
  input  logic [7:0]              configId,
  input  logic [7:0]              configData,
  output logic [N*DATA_WIDTH-1:0] vector_out,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic                    last_out,
  output logic [CIW-1:0]          chainId_out
`ifdef DATA_UNPACKER_DROP_CNT_EN
  ,
  output logic [15:0]             drop_count
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam logic [CW-1:0] LEN_N = CW'(N);
  localparam logic [CW-1:0] LEN_M = CW'(M);
  localparam logic [CW-1:0] LEN_1 = CW'(1);

  // IDLE: no beat; EMIT: beat shown, more buffered; LAST: final beat shown
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [N*DW-1:0]        vec_q, vec_d;
  logic [N*DW-1:0]        buf_q, buf_d;
  logic [CW-1:0]          rem_q, rem_d;
  logic [CW-1:0]          rd_q, rd_d;
  logic [CW-1:0]          len_q, len_d;
  logic [CIW-1:0]         chain_q, chain_d;
  logic [7:0]             fw_q [MAX_CHAINS];

  logic [7:0]             fw_sel_s;
  logic [CW-1:0]          len_in_s;
  logic                   drop_s;
  logic [CW-1:0]          cnt_s;
  logic                   accept_s;
  logic                   load_new_s;
  logic                   load_s;
  logic [N*DW-1:0]        aligned_s;
  logic [N*DW-1:0]        src_s;
  logic [N*DW-1:0]        beat_s;
  logic [CW-1:0]          next_rem_s;
  logic [CW-1:0]          next_rd_s;
  int                     shift_s, start_s, avail_s, len_s, take_s;

  // Firmware lookup for the incoming chain and beat-length decode
  always_comb begin
    fw_sel_s = 8'hFF;  // out-of-range chain ids decode as drop
    for (int c = 0; c < MAX_CHAINS; c++) begin
      if (int'(chainId_in) == c) fw_sel_s = fw_q[c];
    end
    drop_s   = 1'b0;
    len_in_s = LEN_N;
    case (fw_sel_s)
      8'd0:    len_in_s = LEN_N;
      8'd1:    len_in_s = LEN_M;
      8'd2:    len_in_s = LEN_1;
      default: begin
        len_in_s = LEN_N;
        drop_s   = 1'b1;
      end
    endcase
    if (count_in > LEN_N) cnt_s = LEN_N;
    else                  cnt_s = count_in;
  end

  // A new vector may enter when idle, or when the final beat leaves this cycle
  assign ready_in   = tracing && ((state_q == ST_IDLE) ||
                                  (ready_out && (state_q == ST_LAST)));
  assign accept_s   = valid_in && ready_in;
  assign load_new_s = accept_s && !drop_s && (cnt_s != '0);

  // Align valid elements to index 0, then cut the next beat from either the
  // freshly aligned vector or the buffer at the read index
  always_comb begin
    shift_s   = N - int'(cnt_s);
    aligned_s = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        if (k == j + shift_s) aligned_s[j*DW +: DW] = vector_in[k*DW +: DW];
      end
    end
    if (load_new_s) begin
      src_s   = aligned_s;
      start_s = 0;
      avail_s = int'(cnt_s);
      len_s   = int'(len_in_s);
    end else begin
      src_s   = buf_q;
      start_s = int'(rd_q);
      avail_s = int'(rem_q);
      len_s   = int'(len_q);
    end
    if (len_s < avail_s) take_s = len_s;
    else                 take_s = avail_s;
    beat_s = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        if ((j < take_s) && (k == start_s + j)) beat_s[j*DW +: DW] = src_s[k*DW +: DW];
      end
    end
    next_rem_s = CW'(avail_s - take_s);
    next_rd_s  = CW'(start_s + take_s);
  end

  // Next-state logic for the drain FSM and its datapath registers
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    buf_d   = buf_q;
    rem_d   = rem_q;
    rd_d    = rd_q;
    len_d   = len_q;
    chain_d = chain_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: load_s = load_new_s;
      ST_EMIT: load_s = ready_out;
      ST_LAST: begin
        if (ready_out) begin
          load_s = load_new_s;
          if (!load_new_s) state_d = ST_IDLE;
          else             state_d = state_q;
        end else begin
          load_s = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_s) begin
      vec_d   = beat_s;
      rem_d   = next_rem_s;
      rd_d    = next_rd_s;
      state_d = (next_rem_s == '0) ? ST_LAST : ST_EMIT;
    end else begin
      vec_d   = vec_q;
    end
    // chainId and beat length are latched once per vector
    if (load_new_s) begin
      buf_d   = aligned_s;
      len_d   = len_in_s;
      chain_d = chainId_in;
    end else begin
      buf_d   = buf_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      buf_q   <= '0;
      rem_q   <= '0;
      rd_q    <= '0;
      len_q   <= LEN_N;
      chain_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      rd_q    <= rd_d;
      len_q   <= len_d;
      chain_q <= chain_d;
    end
  end

  // Firmware shift register, loaded only while tracing is off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < MAX_CHAINS; c++) fw_q[c] <= INITIAL_FIRMWARE[c*8 +: 8];
    end else if (!tracing && (configId == PERSONAL_CONFIG_ID)) begin
      for (int c = 0; c < MAX_CHAINS - 1; c++) fw_q[c] <= fw_q[c+1];
      fw_q[MAX_CHAINS-1] <= configData;
    end
  end

  assign vector_out  = vec_q;
  assign valid_out   = (state_q != ST_IDLE);
  assign last_out    = (state_q == ST_LAST);
  assign chainId_out = chain_q;

`ifdef DATA_UNPACKER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of vectors accepted without producing beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 16'd0;
    end else if (accept_s && (drop_s || (cnt_s == '0)) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: doc/data_unpacker.md
Name: data_unpacker

Overview:
- Inverse of the trace data packer: accepts packed N-wide vectors and re-emits their elements as beats of N, M or 1 values, selected per chain by firmware.
- Sits on the readback/replay side of the trace buffer, feeding per-chain consumers that expect the original vector granularity.
- Buffers one packed vector and drains it over multiple cycles under ready/valid backpressure.

Parameters:
- N, 8: elements per packed vector and maximum beat width.
- M, 2: medium beat width (1 < M < N, N divisible by M).
- DATA_WIDTH, 32: bits per element.
- MAX_CHAINS, 4: number of chains with their own firmware entry.
- PERSONAL_CONFIG_ID, 0: configId value that addresses this block.
- INITIAL_FIRMWARE, all 0: per-chain 8-bit firmware loaded at reset.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- tracing, in, 1: input acceptance enable.
- valid_in, in, 1: packed vector valid.
- ready_in, out, 1: block can accept vector_in this cycle.
- vector_in, in, N x DATA_WIDTH: packed elements.
- count_in, in, $clog2(N)+1: number of valid elements in vector_in.
- chainId_in, in, $clog2(MAX_CHAINS): chain of the packed vector.
- configId, in, 8: config bus address.
- configData, in, 8: config bus data.
- vector_out, out, N x DATA_WIDTH: unpacked beat.
- valid_out, out, 1: beat valid.
- ready_out, in, 1: downstream accepts the beat.
- last_out, out, 1: final beat of the current packed vector.
- chainId_out, out, $clog2(MAX_CHAINS): chain of the current beat.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - valid_out=0, last_out=0, vector_out all 0, chainId_out=0.
  - Internal buffer, remaining count and read index cleared; firmware loaded from INITIAL_FIRMWARE.
  - Asserting reset mid-drain discards the buffer and forces valid_out=0 immediately.
- Firmware decode, indexed by chainId_in: 0 gives beat length L=N; 1 gives L=M; 2 gives L=1; any other value means drop.
- Input layout:
  - Valid elements occupy indices N-count_in..N-1; the oldest element is at index N-count_in.
  - count_in > N is clamped to N.
  - count_in == 0 is accepted and produces no beats.
- Handshake:
  - ready_in = tracing && (!valid_out || (ready_out && rem==0)). This is combinational from ready_out.
  - A transfer occurs when valid_in && ready_in.
  - An output beat completes when valid_out && ready_out.
- Accept with L valid: the first beat is registered on the next edge (latency 1). The remaining elements go to the buffer, with rem = count - first beat size, and the read index advanced.
- Beat contents:
  - vector_out[0] holds the oldest element; a beat carries min(L, rem) elements.
  - Unused upper indices are 0, so a partial final beat is zero-padded.
  - chainId_out is latched at accept and held for every beat of that vector.
- last_out=1 on the beat after which rem==0.
- On beat completion:
  - If rem>0, load the next beat.
  - Otherwise, if a new transfer happens in the same cycle, load that vector's first beat. This gives back-to-back output with no bubble.
  - Otherwise, valid_out<=0.
- While valid_out && !ready_out, vector_out, last_out and chainId_out hold stable.
- Drop firmware: the vector is accepted (ready_in behaves as above), produces no beats and does not disturb any in-progress drain.
- tracing deassertion does not abort a drain. Buffered beats continue to be delivered; only new acceptance stops.
- Firmware update:
  - Each cycle with tracing==0 and configId==PERSONAL_CONFIG_ID, firmware shifts: firmware[i]<=firmware[i+1] and firmware[MAX_CHAINS-1]<=configData.
  - The config master holds the match for exactly MAX_CHAINS cycles.
  - Config traffic while tracing==1 is ignored.
- States:
  - IDLE: valid_out=0.
  - EMIT: valid_out=1 and rem>0.
  - LAST: valid_out=1 and rem==0; can accept a new vector.
  - Transitions follow the handshake rules above.

Optional Feature:
- Macro: DATA_UNPACKER_DROP_CNT_EN.
- Defined: adds output drop_count [15:0].
  - Increments on every accepted vector whose firmware is drop or whose count_in==0.
  - Saturates at 16'hFFFF; reset value 0.
- Undefined: the port and counter are absent and drops are silent.

Test Plan (N=8, M=2):
- Passthrough: fw[0]=0; accept chain 0, count_in=8, values 1..8 at indices 0..7 → the next cycle gives one beat vector_out=1..8, last_out=1, chainId_out=0.
- M-unpack: fw[1]=1; accept chain 1, count_in=8, values 10..17 → four consecutive beats {10,11},{12,13},{14,15},{16,17} with upper indices 0. last_out is set only on the fourth beat, and ready_in is low for the first three beat cycles.
- Single/partial: fw[2]=2; accept count_in=3 with values 5,6,7 at indices 5..7 → beats 5,6,7 with last_out on 7. Then with fw=1 and count_in=3 (values a,b,c) → beats {a,b} and {c,0}, last_out on the second.
- Backpressure: during M-unpack, drop ready_out for 2 cycles after beat 2 → beat 2 held stable, no element lost or duplicated. Total is 4 beats in 6 cycles.
- Back-to-back: a new vector is presented with valid_in during a LAST beat with ready_out=1 → accepted in the same cycle, and its first beat follows with no idle cycle.
- Drop/reset: fw[3]=3; accept chain 3 → no valid_out, and drop_count=1 (if enabled). Then assert reset mid-drain of an M vector → valid_out=0 asynchronously, and after release ready_in=1 with the buffer empty.
